// File: rtl/traffic_request_latch.sv
// traffic_request_latch: conditions raw main/first street detectors for the
// two-street traffic-light controller.
//
// Ports:
//   clk                         rising-edge clock
//   rst                         synchronous, active-low reset
//   sensor_main, sensor_first   raw detectors (asynchronous to clk)
//   green_main, green_first     green lamps fed back from the controller
//   waiting_main, waiting_first latched requests to the controller
//   overdue_main, overdue_first request has aged to MAX_AGE
//
// Each street has its own identical channel: 2-flop synchroniser,
// debouncer, request latch cleared by green, and saturating age counter.

module traffic_request_channel #(
  parameter int DEBOUNCE = 3,
  parameter int MAX_AGE  = 15,
  parameter int AGE_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  input  logic green,
  output logic waiting,
  output logic overdue
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE - 1);
  localparam logic [AGE_W-1:0] AGE_MAX =
    AGE_W'(MAX_AGE);

  logic            s1;
  logic            s2;
  logic            deb;
  logic [CW-1:0]   cnt;
  logic [AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      cnt     <= '0;
      waiting <= 1'b0;
      age     <= '0;
    end else begin
      s1 <= sensor;
      s2 <= s1;

      // Any agreement restarts the count, so only an
      // unbroken run of DEBOUNCE disagreements flips deb.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Clear beats set: a street already on green
      // is being served, so its request is moot.
      if (green) begin
        waiting <= 1'b0;
      end else if (deb) begin
        waiting <= 1'b1;
      end

      if (green || !waiting) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + 1'b1;
      end
    end
  end

  assign overdue = (age == AGE_MAX);

endmodule

module traffic_request_latch #(
  parameter int DEBOUNCE = 3,
  parameter int MAX_AGE  = 15,
  parameter int AGE_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_main,
  input  logic sensor_first,
  input  logic green_main,
  input  logic green_first,
  output logic waiting_main,
  output logic waiting_first,
  output logic overdue_main,
  output logic overdue_first
);

  traffic_request_channel #(
    .DEBOUNCE (DEBOUNCE),
    .MAX_AGE  (MAX_AGE),
    .AGE_W    (AGE_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .sensor  (sensor_main),
    .green   (green_main),
    .waiting (waiting_main),
    .overdue (overdue_main)
  );

  traffic_request_channel #(
    .DEBOUNCE (DEBOUNCE),
    .MAX_AGE  (MAX_AGE),
    .AGE_W    (AGE_W)
  ) u_first (
    .clk     (clk),
    .rst     (rst),
    .sensor  (sensor_first),
    .green   (green_first),
    .waiting (waiting_first),
    .overdue (overdue_first)
  );

endmodule

// File: tb/tb_traffic_request_latch.sv
// tb_traffic_request_latch: directed scenarios plus randomized traffic
// compared against a sample-history reference model.
module tb_traffic_request_latch;

  localparam int DEBOUNCE = 3;
  localparam int MAX_AGE  = 15;
  localparam int AGE_W    = 4;
  localparam int HN       = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sensor_main = 1'b0;
  logic sensor_first = 1'b0;
  logic green_main = 1'b0;
  logic green_first = 1'b0;
  logic waiting_main;
  logic waiting_first;
  logic overdue_main;
  logic overdue_first;

  int checks = 0;
  int errors = 0;

  // Model: every sensor sample since reset, the accepted
  // level, the request flag and edges spent waiting.
  bit smp [2][0:HN-1];
  int n = 0;
  bit m_deb  [2];
  bit m_wait [2];
  int m_age  [2];

  always #5 clk = ~clk;

  traffic_request_latch #(
    .DEBOUNCE (DEBOUNCE),
    .MAX_AGE  (MAX_AGE),
    .AGE_W    (AGE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_main   (sensor_main),
    .sensor_first  (sensor_first),
    .green_main    (green_main),
    .green_first   (green_first),
    .waiting_main  (waiting_main),
    .waiting_first (waiting_first),
    .overdue_main  (overdue_main),
    .overdue_first (overdue_first)
  );

  // Synchronised level seen at edge index i is the raw
  // sample taken two edges earlier; before reset it is 0.
  function automatic bit sync_at(int c, int i);
    if (i < 0) return 1'b0;
    return smp[c][i % HN];
  endfunction

  function automatic logic [3:0] expv();
    return {m_wait[1], m_wait[0],
            m_age[1] == MAX_AGE,
            m_age[0] == MAX_AGE};
  endfunction

  function automatic logic [3:0] actv();
    return {waiting_first, waiting_main,
            overdue_first, overdue_main};
  endfunction

  task automatic step();
    bit [1:0] sens;
    bit [1:0] grn;
    bit       dis;
    bit       nd;
    @(posedge clk);
    sens = {sensor_first, sensor_main};
    grn  = {green_first, green_main};
    if (!rst) begin
      n = 0;
      for (int c = 0; c < 2; c++) begin
        m_deb[c]  = 1'b0;
        m_wait[c] = 1'b0;
        m_age[c]  = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        // Accepted level flips once the last DEBOUNCE
        // synchronised samples all disagree with it.
        dis = 1'b1;
        for (int k = 0; k < DEBOUNCE; k++)
          if (sync_at(c, n - 2 - k) == m_deb[c])
            dis = 1'b0;
        nd = dis ? !m_deb[c] : m_deb[c];
        if (grn[c] || !m_wait[c]) m_age[c] = 0;
        else if (m_age[c] < MAX_AGE)
          m_age[c] = m_age[c] + 1;
        if (grn[c]) m_wait[c] = 1'b0;
        else if (m_deb[c]) m_wait[c] = 1'b1;
        m_deb[c] = nd;
        smp[c][n % HN] = sens[c];
      end
      n = n + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sensor_main = 1'b0;
    sensor_first = 1'b0;
    green_main = 1'b0;
    green_first = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sensor_main = 1'b1;
    sensor_first = 1'b1;
    step();
    step();
    checks++;
    if (actv() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000",
               actv());
    end
    rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (waiting_main !== (e >= 6)) begin
        errors++;
        $display("FAIL reset_release e=%0d got=%b want=%b",
                 e, waiting_main, e >= 6);
      end
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL reset_model e=%0d got=%b want=%b",
                 e, actv(), expv());
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sensor_main = 1'b1;
    step();
    step();
    sensor_main = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (waiting_main !== 1'b0 ||
          actv() !== expv()) begin
        errors++;
        $display("FAIL glitch e=%0d got=%b want=%b",
                 e, actv(), expv());
      end
    end
  endtask

  task automatic test_latch_clear();
    do_reset();
    sensor_first = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 5) sensor_first = 1'b0;
      checks++;
      if (waiting_first !== (e >= 6) ||
          actv() !== expv()) begin
        errors++;
        $display("FAIL latch e=%0d got=%b want_wf=%b",
                 e, actv(), e >= 6);
      end
    end
    green_first = 1'b1;
    step();
    green_first = 1'b0;
    checks++;
    if (waiting_first !== 1'b0) begin
      errors++;
      $display("FAIL clear got=%b want=0",
               waiting_first);
    end
    step();
    checks++;
    if (waiting_first !== 1'b0 ||
        actv() !== expv()) begin
      errors++;
      $display("FAIL clear_hold got=%b want=%b",
               actv(), expv());
    end
  endtask

  task automatic test_overdue();
    int t;
    do_reset();
    sensor_main = 1'b1;
    t = 0;
    while (waiting_main !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    checks++;
    if (waiting_main !== 1'b1) begin
      errors++;
      $display("FAIL overdue_arm got=%b want=1",
               waiting_main);
    end
    for (int e = 1; e <= 25; e++) begin
      step();
      checks++;
      if (overdue_main !== (e >= 15) ||
          actv() !== expv()) begin
        errors++;
        $display("FAIL overdue e=%0d got=%b want_om=%b",
                 e, actv(), e >= 15);
      end
    end
    green_main = 1'b1;
    step();
    green_main = 1'b0;
    sensor_main = 1'b0;
    checks++;
    if (overdue_main !== 1'b0 ||
        waiting_main !== 1'b0) begin
      errors++;
      $display("FAIL overdue_clear got=%b%b want=00",
               waiting_main, overdue_main);
    end
  endtask

  task automatic test_collision();
    do_reset();
    green_main = 1'b1;
    sensor_main = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      checks++;
      if (waiting_main !== 1'b0 ||
          actv() !== expv()) begin
        errors++;
        $display("FAIL collision e=%0d got=%b want=%b",
                 e, actv(), expv());
      end
    end
    green_main = 1'b0;
    step();
    checks++;
    if (waiting_main !== 1'b1) begin
      errors++;
      $display("FAIL rearm got=%b want=1",
               waiting_main);
    end
    sensor_main = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    sensor_first = 1'b1;
    t = 0;
    while (waiting_first !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    for (int e = 0; e < 7; e++) step();
    checks++;
    if (m_age[1] != 7 || actv() !== expv()) begin
      errors++;
      $display("FAIL midwait_pre got=%b want=%b age=%0d",
               actv(), expv(), m_age[1]);
    end
    rst = 1'b0;
    step();
    checks++;
    if (actv() !== 4'b0000) begin
      errors++;
      $display("FAIL midwait_reset got=%b want=0000",
               actv());
    end
    rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (waiting_first !== (e >= DEBOUNCE + 3)) begin
        errors++;
        $display("FAIL midwait_rearm e=%0d got=%b want=%b",
                 e, waiting_first, e >= DEBOUNCE + 3);
      end
    end
    sensor_first = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int e = 0; e < 2000; e++) begin
      if ($urandom_range(99) < 15)
        sensor_main = ~sensor_main;
      if ($urandom_range(99) < 15)
        sensor_first = ~sensor_first;
      green_main  = ($urandom_range(99) < 4);
      green_first = ($urandom_range(99) < 4);
      rst = ($urandom_range(299) != 0);
      step();
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL random e=%0d got=%b want=%b",
                 e, actv(), expv());
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latch_clear();
    test_overdue();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
